// File: rtl/tmds_decoder.sv
// Single-channel TMDS receive decoder for a DVI sink.
// Stage 1 registers the raw deserialized word. Stage 2 classifies it as a
// control token or data, decodes it and registers the outputs.
// A word-alignment FSM running on the stage-1 word requests bitslips from
// the deserializer until it sees a run of control tokens.
module tmds_decoder #(
  parameter int CTRL_RUN   = 8,
  parameter int SEARCH_LEN = 2048,
  parameter int SLIP_HOLD  = 16,
  parameter int LOCK_LOSS  = 4096
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic [9:0] tmds_i,
  output logic [7:0] data_o,
  output logic       de_o,
  output logic [1:0] c_o,
  output logic       locked_o,
  output logic       bitslip_o
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WORD_W = $clog2(SEARCH_LEN + 1);
  localparam int HOLD_W = $clog2(SLIP_HOLD + 1);
  localparam int GAP_W  = $clog2(LOCK_LOSS + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_RUN);
  localparam logic [WORD_W-1:0] WORD_MAX  = WORD_W'(SEARCH_LEN);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(SEARCH_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(SLIP_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLIP_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(LOCK_LOSS);

  typedef enum logic [1:0] {
    SEARCH,
    SLIP_WAIT,
    LOCKED
  } state_t;

  state_t              state, state_n;
  logic [9:0]          w;
  logic [RUN_W-1:0]    run, run_n;
  logic [WORD_W-1:0]   word, word_n;
  logic [HOLD_W-1:0]   hold, hold_n;
  logic [GAP_W-1:0]    gap, gap_n;
  logic                locked_n;
  logic                slip_n;
  logic                is_tok;
  logic [1:0]          tok_c;
  logic [7:0]          q;
  logic [7:0]          d;

  // Stage 1: capture the raw word from the deserializer.
  always_ff @(posedge clk_pix) begin
    if (rst) w <= '0;
    else     w <= tmds_i;
  end

  // Recognise the four control tokens.
  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (w)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    q    = w[9] ? ~w[7:0] : w[7:0];
    d    = '0;
    d[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Alignment FSM: next state, counters, lock flag and slip request.
  always_comb begin
    state_n  = state;
    run_n    = run;
    word_n   = word;
    hold_n   = hold;
    gap_n    = gap;
    locked_n = locked_o;
    slip_n   = 1'b0;
    case (state)
      SEARCH: begin
        run_n  = !is_tok ? '0 : ((run == RUN_MAX) ? run : run + 1'b1);
        word_n = (word == WORD_MAX) ? word : word + 1'b1;
        // Lock is checked first so it wins over a slip in the same cycle.
        if (run_n == RUN_MAX) begin
          state_n  = LOCKED;
          locked_n = 1'b1;
          run_n    = '0;
          word_n   = '0;
          gap_n    = '0;
        end else if (word == WORD_LAST) begin
          state_n = SLIP_WAIT;
          slip_n  = 1'b1;
          run_n   = '0;
          word_n  = '0;
          hold_n  = '0;
        end
      end
      SLIP_WAIT: begin
        hold_n = (hold == HOLD_MAX) ? hold : hold + 1'b1;
        if (hold == HOLD_LAST) begin
          state_n = SEARCH;
          hold_n  = '0;
          run_n   = '0;
          word_n  = '0;
        end
      end
      LOCKED: begin
        gap_n = is_tok ? '0 : ((gap == GAP_MAX) ? gap : gap + 1'b1);
        if (gap_n == GAP_MAX) begin
          state_n  = SEARCH;
          locked_n = 1'b0;
          gap_n    = '0;
          run_n    = '0;
          word_n   = '0;
        end
      end
      default: begin
        state_n  = SEARCH;
        locked_n = 1'b0;
      end
    endcase
  end

  // Alignment FSM state and counter registers.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state     <= SEARCH;
      run       <= '0;
      word      <= '0;
      hold      <= '0;
      gap       <= '0;
      locked_o  <= 1'b0;
      bitslip_o <= 1'b0;
    end else begin
      state     <= state_n;
      run       <= run_n;
      word      <= word_n;
      hold      <= hold_n;
      gap       <= gap_n;
      locked_o  <= locked_n;
      bitslip_o <= slip_n;
    end
  end

  // Stage 2: decoded outputs; gating on locked_n keeps de_o/data_o in step
  // with the locked_o value registered on the same edge.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      data_o <= '0;
      de_o   <= 1'b0;
      c_o    <= '0;
    end else if (is_tok) begin
      data_o <= '0;
      de_o   <= 1'b0;
      c_o    <= tok_c;
    end else begin
      data_o <= locked_n ? d : '0;
      de_o   <= locked_n;
    end
  end

endmodule
